// File: rtl/instr_controller.sv
// Multi-cycle instruction controller: latches a 16-bit instruction, decodes it and
// sequences register-file, A/B, ALU, C and status enables as a Moore FSM.
module instr_controller (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        loadc,
  output logic        loads,
  output logic [15:0] sximm8,
  output logic        illegal
);

  localparam int unsigned IW = 16;
  localparam int unsigned IMMW = 8;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_COMPUTE, S_WRITE_REG
  } state_t;

  state_t        state, next_state;
  logic [IW-1:0] ir;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign sximm8 = {{(IW-IMMW){ir[IMMW-1]}}, ir[IMMW-1:0]};
  assign bsel   = 1'b0;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_WAIT;
    else          state <= next_state;
  end

  // Instruction register: only writable while idle so IR holds for the whole instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   ir <= '0;
    else if (state == S_WAIT && load) ir <= in;
  end

  // Next-state and Moore output decode
  always_comb begin
    next_state = state;
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = 2'b00;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    loadc    = 1'b0;
    loads    = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) next_state = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == 3'b110 && op == 2'b10)      next_state = S_WRITE_IMM;
        else if (opcode == 3'b110 && op == 2'b00) next_state = S_GET_B;
        else if (opcode == 3'b101 && op == 2'b11) next_state = S_GET_B;
        else if (opcode == 3'b101)                next_state = S_GET_A;
        else begin
          next_state = S_WAIT;
          illegal    = 1'b1;
        end
      end
      S_WRITE_IMM: begin
        writenum   = rn;
        vsel       = 2'b10;
        write      = 1'b1;
        next_state = S_WAIT;
      end
      S_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        next_state = S_GET_B;
      end
      S_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        next_state = S_COMPUTE;
      end
      S_COMPUTE: begin
        shift = sh;
        // MOV-reg passes B through with a zero A operand
        if (opcode == 3'b101) begin
          asel  = 1'b1;
          ALUop = op;
        end
        if (opcode == 3'b101 && op == 2'b01) begin
          loads      = 1'b1;
          next_state = S_WAIT;
        end else begin
          loadc      = 1'b1;
          next_state = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum   = rd;
        write      = 1'b1;
        next_state = S_WAIT;
      end
      default: next_state = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_instr_controller.sv
// Bench for instr_controller: cycle-by-cycle vector table plus a reset-abort sequence.
module tb_instr_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] in;
  logic        load, s;
  logic        w, write, loada, loadb, asel, bsel, loadc, loads, illegal;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8;

  instr_controller dut (
    .clk(clk), .reset_n(reset_n), .in(in), .load(load), .s(s),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift),
    .ALUop(ALUop), .loadc(loadc), .loads(loads), .sximm8(sximm8), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  alu;
    logic        loadc;
    logic        loads;
    logic        illegal;
    logic [15:0] sx;
  } outs_t;

  typedef struct {
    logic        load;
    logic        s;
    logic [15:0] in;
    outs_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic outs_t busy(input logic [15:0] sx);
    outs_t o = '0;
    o.sx = sx;
    return o;
  endfunction

  function automatic outs_t idle(input logic [15:0] sx);
    outs_t o = busy(sx);
    o.w = 1'b1;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.w = w; o.readnum = readnum; o.writenum = writenum; o.write = write;
    o.vsel = vsel; o.loada = loada; o.loadb = loadb; o.asel = asel; o.bsel = bsel;
    o.shift = shift; o.alu = ALUop; o.loadc = loadc; o.loads = loads;
    o.illegal = illegal; o.sx = sximm8;
    return o;
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic st, input logic [15:0] i, input outs_t e);
    vec_t v;
    v.load = ld; v.s = st; v.in = i; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    outs_t e;
    // MOV R2,#-16
    add(1, 0, 16'hD2F0, idle(16'hFFF0));
    add(0, 1, 16'h0000, busy(16'hFFF0));
    e = busy(16'hFFF0); e.writenum = 3'd2; e.vsel = 2'b10; e.write = 1'b1;
    add(0, 0, 16'h0000, e);
    add(0, 0, 16'h0000, idle(16'hFFF0));
    // ADD R5,R1,R0,LSL#1 with load and s together
    add(1, 1, 16'hA1A8, busy(16'hFFA8));
    e = busy(16'hFFA8); e.readnum = 3'd1; e.loada = 1'b1;
    add(0, 0, 16'h0000, e);
    e = busy(16'hFFA8); e.readnum = 3'd0; e.loadb = 1'b1;
    add(0, 0, 16'h0000, e);
    e = busy(16'hFFA8); e.shift = 2'b01; e.alu = 2'b00; e.asel = 1'b1; e.loadc = 1'b1;
    add(0, 0, 16'h0000, e);
    e = busy(16'hFFA8); e.writenum = 3'd5; e.write = 1'b1;
    add(0, 0, 16'h0000, e);
    add(0, 0, 16'h0000, idle(16'hFFA8));
    // CMP R1,R2
    add(1, 0, 16'hA902, idle(16'h0002));
    add(0, 1, 16'h0000, busy(16'h0002));
    e = busy(16'h0002); e.readnum = 3'd1; e.loada = 1'b1;
    add(0, 0, 16'h0000, e);
    e = busy(16'h0002); e.readnum = 3'd2; e.loadb = 1'b1;
    add(0, 0, 16'h0000, e);
    e = busy(16'h0002); e.alu = 2'b01; e.asel = 1'b1; e.loads = 1'b1;
    add(0, 0, 16'h0000, e);
    add(0, 0, 16'h0000, idle(16'h0002));
    // MVN R7,R3 then MOV R2,R3 back-to-back
    add(1, 1, 16'hB8E3, busy(16'hFFE3));
    e = busy(16'hFFE3); e.readnum = 3'd3; e.loadb = 1'b1;
    add(0, 0, 16'h0000, e);
    e = busy(16'hFFE3); e.alu = 2'b11; e.asel = 1'b1; e.loadc = 1'b1;
    add(0, 0, 16'h0000, e);
    e = busy(16'hFFE3); e.writenum = 3'd7; e.write = 1'b1;
    add(0, 0, 16'h0000, e);
    add(0, 0, 16'h0000, idle(16'hFFE3));
    add(1, 1, 16'hC043, busy(16'h0043));
    e = busy(16'h0043); e.readnum = 3'd3; e.loadb = 1'b1;
    add(0, 0, 16'h0000, e);
    e = busy(16'h0043); e.loadc = 1'b1;
    add(0, 0, 16'h0000, e);
    e = busy(16'h0043); e.writenum = 3'd2; e.write = 1'b1;
    add(0, 0, 16'h0000, e);
    add(0, 0, 16'h0000, idle(16'h0043));
    // Illegal opcode, then load attempted during DECODE
    e = busy(16'h0000); e.illegal = 1'b1;
    add(1, 1, 16'hE000, e);
    add(1, 0, 16'hD2F0, idle(16'h0000));
    // ADD again with load/s held high while busy: IR must not change
    add(1, 1, 16'hA1A8, busy(16'hFFA8));
    e = busy(16'hFFA8); e.readnum = 3'd1; e.loada = 1'b1;
    add(1, 1, 16'hE000, e);
    e = busy(16'hFFA8); e.readnum = 3'd0; e.loadb = 1'b1;
    add(1, 1, 16'hE000, e);
    e = busy(16'hFFA8); e.shift = 2'b01; e.asel = 1'b1; e.loadc = 1'b1;
    add(1, 1, 16'hE000, e);
    e = busy(16'hFFA8); e.writenum = 3'd5; e.write = 1'b1;
    add(0, 0, 16'h0000, e);
    add(0, 0, 16'h0000, idle(16'hFFA8));
  endtask

  initial begin
    outs_t e;
    reset_n = 1'b0; in = '0; load = 1'b0; s = 1'b0;
    build_table();
    #12;
    check("reset_idle", sample(), idle(16'h0000));
    @(negedge clk) reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      load = vecs[i].load; s = vecs[i].s; in = vecs[i].in;
      @(posedge clk);
      #1;
      check($sformatf("vec[%0d]", i), sample(), vecs[i].exp);
    end

    // Abort an ADD in COMPUTE with an asynchronous reset
    @(negedge clk);
    load = 1'b1; s = 1'b1; in = 16'hA1A8;
    @(negedge clk);
    load = 1'b0; s = 1'b0; in = '0;
    repeat (3) @(posedge clk);
    #1;
    e = busy(16'hFFA8); e.shift = 2'b01; e.asel = 1'b1; e.loadc = 1'b1;
    check("abort_in_compute", sample(), e);
    #2 reset_n = 1'b0;
    #1;
    check("abort_immediate", sample(), idle(16'h0000));
    @(posedge clk); #1;
    check("abort_held", sample(), idle(16'h0000));
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("after_release_1", sample(), idle(16'h0000));
    @(posedge clk); #1;
    check("after_release_2", sample(), idle(16'h0000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
